// File: rtl/uncache_store_scheduler.sv
// Arbitrates the single uncached memory port: posted stores drain in order from a
// small FIFO, and a blocking load issues only once every older store has completed.
module uncache_store_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [3:0]        st_wen,
    output logic              st_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_data_ok,
    output logic              unc_en,
    output logic              unc_rw,
    output logic [ADDR_W-1:0] unc_addr,
    output logic [DATA_W-1:0] unc_wdata,
    output logic [3:0]        unc_wen,
    input  logic [DATA_W-1:0] unc_rdata,
    input  logic              unc_data_ok,
    output logic              buf_empty,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ST   = 2'd1;
    localparam logic [1:0] S_LD   = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              cancel_q;
    logic [ADDR_W-1:0] ld_addr_q;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [3:0]        wen_mem  [DEPTH];

    logic push;
    logic pop;

    assign st_ready  = (count != FULL_CNT);
    assign push      = st_en & st_ready;
    assign pop       = (state == S_ST) & unc_data_ok;
    assign busy      = (state != S_IDLE);
    assign buf_empty = (count == '0) & (state == S_IDLE);

    // Entry storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= st_addr;
            data_mem[tail] <= st_data;
            wen_mem[tail]  <= st_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Every transaction returns through IDLE, so unc_en always drops for a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cancel_q  <= 1'b0;
            ld_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cancel_q <= 1'b0;
                    if (count != '0) begin
                        state <= S_ST;
                    end else if (ld_en & ~flush) begin
                        state     <= S_LD;
                        ld_addr_q <= ld_addr;
                    end
                end
                S_ST: begin
                    if (unc_data_ok) state <= S_IDLE;
                end
                S_LD: begin
                    if (unc_data_ok) begin
                        state    <= S_IDLE;
                        cancel_q <= 1'b0;
                    end else if (flush) begin
                        cancel_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        unc_en     = 1'b0;
        unc_rw     = 1'b0;
        unc_addr   = '0;
        unc_wdata  = '0;
        unc_wen    = 4'b0000;
        ld_data_ok = 1'b0;
        case (state)
            S_ST: begin
                unc_en    = 1'b1;
                unc_rw    = 1'b1;
                unc_addr  = addr_mem[head];
                unc_wdata = data_mem[head];
                unc_wen   = wen_mem[head];
            end
            S_LD: begin
                unc_en     = 1'b1;
                unc_addr   = ld_addr_q;
                ld_data_ok = unc_data_ok & ~cancel_q;
            end
            default: ;
        endcase
        ld_data = ld_data_ok ? unc_rdata : '0;
    end

endmodule
